// File: rtl/instruction_decode_stage_pkg.sv
// Shared widths, instruction field positions and the decoded bundle
// used by the decode stage and its consumers.
package instruction_decode_stage_pkg;

    localparam int INSTR_W = 32;
    localparam int OPC_W   = 5;
    localparam int REG_AW  = 4;
    localparam int NUM_OPC = 20;

    localparam int OPC_MSB     = 31;
    localparam int OPC_LSB     = 27;
    localparam int IMM_SEL_BIT = 26;
    localparam int RD_MSB      = 25;
    localparam int RD_LSB      = 22;
    localparam int RN_MSB      = 21;
    localparam int RN_LSB      = 18;
    localparam int RM_MSB      = 17;
    localparam int RM_LSB      = 14;
    localparam int IMM8_MSB    = 7;
    localparam int IMM8_LSB    = 0;

    localparam int PAYLOAD_W = 2 * INSTR_W;

    typedef struct packed {
        logic [OPC_W-1:0]   opcode;
        logic               imm_sel;
        logic [REG_AW-1:0]  rd;
        logic [REG_AW-1:0]  rn;
        logic [REG_AW-1:0]  rm;
        logic [7:0]         imm_8;
        logic [INSTR_W-1:0] pc;
        logic               illegal;
    } decoded_t;

    function automatic logic is_illegal(input logic [OPC_W-1:0] opc);
        return int'(opc) >= NUM_OPC;
    endfunction

endpackage

// File: rtl/decode_skid_buffer.sv
// Two-entry valid/ready register pair: output register plus one skid
// entry, so in_ready can come straight from a flop.
module decode_skid_buffer #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         in_ready_q, in_ready_d;
    logic         accept, emit;

    assign accept = in_valid && in_ready_q;
    assign emit   = out_valid_q && out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (emit) begin
            // skid is always older than anything arriving this cycle
            if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_data_d = in_data;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q) begin
                out_data_d  = in_data;
                out_valid_d = 1'b1;
            end else begin
                skid_data_d  = in_data;
                skid_valid_d = 1'b1;
            end
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/instruction_decode_stage.sv
// Decode stage: buffers fetch words in a skid pair, splits the presented
// word into fields and counts completed handshakes to execute.
module instruction_decode_stage
    import instruction_decode_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [INSTR_W-1:0] in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OPC_W-1:0]   out_opcode,
    output logic               out_imm_sel,
    output logic [REG_AW-1:0]  out_rd,
    output logic [REG_AW-1:0]  out_rn,
    output logic [REG_AW-1:0]  out_rm,
    output logic [7:0]         out_imm_8,
    output logic [INSTR_W-1:0] out_pc,
    output logic               out_illegal,
    output logic [15:0]        decode_count
);

    logic [PAYLOAD_W-1:0] held;
    logic [INSTR_W-1:0]   instr;
    logic [5:0]           unused_bits;
    decoded_t             dec;
    logic [15:0]          count_q, count_d;

    decode_skid_buffer #(.W(PAYLOAD_W)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({in_pc, in_instr}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (held)
    );

    assign instr       = held[INSTR_W-1:0];
    assign unused_bits = instr[13:8];

    always_comb begin
        dec         = '0;
        dec.opcode  = instr[OPC_MSB:OPC_LSB];
        dec.imm_sel = instr[IMM_SEL_BIT];
        dec.rd      = instr[RD_MSB:RD_LSB];
        dec.rn      = instr[RN_MSB:RN_LSB];
        dec.rm      = instr[RM_MSB:RM_LSB];
        dec.imm_8   = instr[IMM8_MSB:IMM8_LSB];
        dec.pc      = held[PAYLOAD_W-1:INSTR_W];
        dec.illegal = is_illegal(dec.opcode);
    end

    // flush does not clear the count; an emit in the flush cycle still counts
    always_comb begin
        count_d = count_q;
        if (out_valid && out_ready) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign out_opcode   = dec.opcode;
    assign out_imm_sel  = dec.imm_sel;
    assign out_rd       = dec.rd;
    assign out_rn       = dec.rn;
    assign out_rm       = dec.rm;
    assign out_imm_8    = dec.imm_8;
    assign out_pc       = dec.pc;
    assign out_illegal  = dec.illegal;
    assign decode_count = count_q;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Directed plus random bench for instruction_decode_stage, checked
// against a queue-based model of the stage's occupancy and ordering.
module tb_instruction_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_opcode;
    logic        out_imm_sel;
    logic [3:0]  out_rd;
    logic [3:0]  out_rn;
    logic [3:0]  out_rm;
    logic [7:0]  out_imm_8;
    logic [31:0] out_pc;
    logic        out_illegal;
    logic [15:0] decode_count;

    instruction_decode_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_opcode   (out_opcode),
        .out_imm_sel  (out_imm_sel),
        .out_rd       (out_rd),
        .out_rn       (out_rn),
        .out_rm       (out_rm),
        .out_imm_8    (out_imm_8),
        .out_pc       (out_pc),
        .out_illegal  (out_illegal),
        .decode_count (decode_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] mq[$];
    logic        m_ready;
    logic [15:0] m_count;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: the stage holds at most two words in arrival order.
    task automatic model_update();
        if (!rst_n) begin
            mq.delete();
            m_ready = 1'b0;
            m_count = 16'd0;
        end else begin
            logic was_ready;
            was_ready = m_ready;
            if (mq.size() > 0 && out_ready) begin
                m_count = m_count + 16'd1;
                void'(mq.pop_front());
            end
            if (flush) mq.delete();
            else if (in_valid && was_ready) mq.push_back({in_pc, in_instr});
            m_ready = (mq.size() < 2);
        end
    endtask

    task automatic check_model();
        logic [31:0] w;
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
        chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
        chk("decode_count", {16'd0, decode_count}, {16'd0, m_count});
        if (mq.size() > 0) begin
            w = mq[0][31:0];
            chk("opcode", {27'd0, out_opcode}, w >> 27);
            chk("imm_sel", {31'd0, out_imm_sel}, (w >> 26) & 32'h1);
            chk("rd", {28'd0, out_rd}, (w >> 22) & 32'hF);
            chk("rn", {28'd0, out_rn}, (w >> 18) & 32'hF);
            chk("rm", {28'd0, out_rm}, (w >> 14) & 32'hF);
            chk("imm_8", {24'd0, out_imm_8}, w & 32'hFF);
            chk("pc", out_pc, mq[0][63:32]);
            chk("illegal", {31'd0, out_illegal},
                {31'd0, (w >> 27) >= 32'd20});
        end
    endtask

    task automatic step(input bit do_check);
        @(posedge clk);
        model_update();
        #1;
        if (do_check) check_model();
    endtask

    task automatic check_reset_outputs();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_fields", {out_opcode, out_imm_sel, out_rd, out_rn,
            out_rm, out_imm_8, out_illegal}, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_count", {16'd0, decode_count}, 32'd0);
    endtask

    logic [15:0] base;
    int guard;

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1;
        in_instr = 32'hFFFF_FFFF; in_pc = 32'h1234; out_ready = 1'b0;
        m_ready = 1'b0; m_count = 16'd0;

        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            check_reset_outputs();
        end
        rst_n = 1'b1; in_valid = 1'b0;
        step(1'b1);
        chk("ready_after_reset", {31'd0, in_ready}, 32'd1);

        in_valid = 1'b1; in_instr = 32'h1E49_40A5; in_pc = 32'h40;
        out_ready = 1'b1;
        step(1'b1);
        chk("dec_opcode", {27'd0, out_opcode}, 32'd3);
        chk("dec_imm_sel", {31'd0, out_imm_sel}, 32'd1);
        chk("dec_rd", {28'd0, out_rd}, 32'd9);
        chk("dec_rn", {28'd0, out_rn}, 32'd2);
        chk("dec_rm", {28'd0, out_rm}, 32'd5);
        chk("dec_imm8", {24'd0, out_imm_8}, 32'hA5);
        chk("dec_pc", out_pc, 32'h40);
        chk("dec_illegal", {31'd0, out_illegal}, 32'd0);
        in_valid = 1'b0;
        step(1'b1);

        base = m_count;
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = $urandom; in_pc = 32'h100;
        step(1'b1);
        in_instr = $urandom; in_pc = 32'h104;
        step(1'b1);
        chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
        chk("bp_hold_a", out_pc, 32'h100);
        in_instr = $urandom; in_pc = 32'h108;
        step(1'b1);
        chk("bp_c_blocked", out_pc, 32'h100);
        out_ready = 1'b1;
        step(1'b1);
        chk("bp_order_b", out_pc, 32'h104);
        step(1'b1);
        chk("bp_order_c", out_pc, 32'h108);
        in_valid = 1'b0;
        step(1'b1);
        chk("bp_count", {16'd0, decode_count - base}, 32'd3);

        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = $urandom; in_pc = 32'h200;
        step(1'b1);
        in_pc = 32'h204;
        step(1'b1);
        base = decode_count;
        flush = 1'b1; in_pc = 32'h208;
        step(1'b1);
        chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
        chk("fl_count", {16'd0, decode_count}, {16'd0, base});
        flush = 1'b0; in_valid = 1'b0;
        step(1'b1);
        chk("fl_dropped", {31'd0, out_valid}, 32'd0);

        out_ready = 1'b1; in_valid = 1'b1;
        in_instr = {5'd20, 27'($urandom)}; in_pc = 32'h300;
        step(1'b1);
        chk("illegal_20", {31'd0, out_illegal}, 32'd1);
        in_instr = {5'd19, 27'($urandom)}; in_pc = 32'h304;
        step(1'b1);
        chk("legal_19", {31'd0, out_illegal}, 32'd0);
        chk("illegal_20_emitted", {16'd0, decode_count - base}, 32'd1);
        in_valid = 1'b0;
        step(1'b1);

        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_instr  = $urandom;
            in_pc     = $urandom;
            step(1'b1);
        end
        flush = 1'b0;

        in_valid = 1'b1; out_ready = 1'b1;
        guard = 0;
        while (m_count != 16'hFFFF && guard < 70000) begin
            in_instr = $urandom; in_pc = $urandom;
            step(1'b0);
            guard++;
        end
        check_model();
        chk("wrap_pre", {16'd0, decode_count}, 32'hFFFF);
        in_valid = 1'b0;
        step(1'b1);
        chk("wrap_zero", {16'd0, decode_count}, 32'd0);
        flush = 1'b1; in_valid = 1'b1;
        step(1'b1);
        chk("wrap_flush_count", {16'd0, decode_count}, 32'd0);
        flush = 1'b0; in_valid = 1'b0;
        step(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_decode_stage.md
Name: instruction_decode_stage

Overview:
Decode pipeline stage between instruction fetch and execute. It accepts a 32-bit instruction and its PC over a valid/ready handshake. It splits the instruction into opcode, register addresses and the raw 8-bit immediate; the immediate drives the Zero_Extend_8 input in execute. A one-entry skid buffer keeps in_ready registered, and a flush input discards in-flight instructions on branch redirect.

Parameters:
INSTR_W, 32, instruction and PC width
OPC_W, 5, opcode field width (instr[31:27])
REG_AW, 4, register address width
NUM_OPC, 20, opcodes 0..NUM_OPC-1 are legal

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
flush  input  1  synchronous discard of all held instructions
in_valid  input  1  fetch presents instruction
in_ready  output  1  stage can accept (registered)
in_instr  input  INSTR_W  instruction word
in_pc  input  INSTR_W  PC of instruction
out_valid  output  1  decoded instruction available
out_ready  input  1  execute accepts
out_opcode  output  OPC_W  instr[31:27]
out_imm_sel  output  1  instr[26]; 1 = use immediate operand
out_rd  output  REG_AW  instr[25:22]
out_rn  output  REG_AW  instr[21:18]
out_rm  output  REG_AW  instr[17:14]
out_imm_8  output  8  instr[7:0], to Zero_Extend_8
out_pc  output  INSTR_W  PC passed through
out_illegal  output  1  opcode >= NUM_OPC
decode_count  output  16  count of completed output handshakes

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - all outputs 0, including in_ready and decode_count; skid buffer empty.
  - in_ready rises to 1 on the first edge with rst_n=1.
- Accept condition: in_valid && in_ready.
- Emit condition: out_valid && out_ready.
- Field extraction is purely combinational on the captured word; instr[13:8] is ignored.
- out_illegal = (opcode >= NUM_OPC). The instruction still flows through; execute handles the trap.
- Latency: an instruction accepted at edge N is on the outputs with out_valid=1 after edge N, if the output register is free or being emitted at N.
- Output register load on accept:
  - If out_valid=0, or an emit happens in the same cycle, the accepted instruction loads directly into the output register.
  - Otherwise it goes to the skid register, skid becomes full, and in_ready=0 from the next cycle.
- Skid drain: on emit while skid is full, the skid contents move to the output register, skid empties, and in_ready=1 from the next cycle.
- Emit with no accept and empty skid: out_valid=0 next cycle.
- Ordering is strictly FIFO; no instruction is duplicated or lost except by flush.
- Output fields hold their value while out_valid && !out_ready. The stage never changes a presented instruction before it is accepted downstream.
- flush=1 at an edge:
  - out_valid=0 and skid empty after the edge; any instruction accepted in that same cycle is dropped.
  - in_ready=1 after the edge.
  - An emit handshake in the flush cycle still counts.
  - flush has priority over all other events. flush and rst_n=0 together behave as reset.
- decode_count increments by 1 per emit and wraps 0xFFFF -> 0x0000. Only reset clears it; flush does not.
- Throughput: 1 instruction per cycle while out_ready=1.

Decomposition:
- Shared package holds:
  - field bit-position constants (OPC_MSB=31, OPC_LSB=27, IMM_SEL_BIT=26, RD/RN/RM positions, IMM8 positions);
  - NUM_OPC;
  - the decoded-instruction bundle typedef {opcode, imm_sel, rd, rn, rm, imm_8, pc, illegal}.
- One natural sub-module: decode_skid_buffer, a generic 2-entry valid/ready register pair parameterised on payload width. The top level wraps it with the field-extraction logic and the counter.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> all outputs 0 and in_ready=0 throughout; in_ready=1 one cycle after release.
2. Field decode: in_instr=0x1E4940A5, pc=0x40, out_ready=1 -> next cycle:
   - out_opcode=3, out_imm_sel=1, out_rd=9, out_rn=2, out_rm=5, out_imm_8=0xA5;
   - out_pc=0x40, out_illegal=0.
3. Backpressure: stream A, B, C with out_ready=0 ->
   - A held on outputs, B in skid, in_ready=0, C not accepted.
   - Raise out_ready -> A, B, C emitted in order; decode_count=3.
4. Flush: skid full and out_valid=1, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, the new instruction is dropped, decode_count unchanged.
5. Illegal opcode: instr[31:27]=20 -> out_illegal=1, instruction still emitted. Opcode 19 -> out_illegal=0.
6. Counter wrap: preload by 65535 emits, emit one more -> decode_count=0x0000. A following flush leaves the count unchanged.
